// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, mode-0 idle levels and receiver FSM states.
// Reusable by both the receive and transmit sides of the display link.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic SS_IDLE   = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/spi_sseg_rx_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with a history flop
// that produces single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Reset preloads the idle level so no spurious edge follows reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_sseg_rx.sv
// SPI mode-0 slave receiver: oversamples the link, assembles MSB-first bytes
// into WORD_BYTES-byte words and flags frames that end mid-byte or mid-word.
module spi_sseg_rx
  import spi_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    ss,
  input  logic                    sdi,
  output logic [SPI_BYTE_W-1:0]   byte_dat,
  output logic                    byte_vld,
  output logic [8*WORD_BYTES-1:0] word_dat,
  output logic                    word_vld,
  output logic                    frm_err,
  output logic                    busy
);

  localparam int WORD_W = SPI_BYTE_W * WORD_BYTES;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);

  rx_state_t             state;
  logic [SPI_BYTE_W-1:0] shift;
  logic [2:0]            bit_cnt;
  logic [BC_W-1:0]       byte_cnt;
  logic [WORD_W-1:0]     word_acc;

  logic sclk_rise, ss_rise, ss_fall, sdi_q;
  logic sclk_q_unused, sclk_fall_unused, ss_q_unused;
  logic sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SS_IDLE)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .din(ss),
    .q(ss_q_unused), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .din(sdi),
    .q(sdi_q), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  logic [SPI_BYTE_W-1:0] full_byte;
  logic [WORD_W-1:0]     next_acc;
  logic [2:0]            bit_cnt_nxt;
  logic [BC_W-1:0]       byte_cnt_nxt;
  logic                  byte_done, word_done;

  // Post-sample counters; the end-of-frame check looks at these so a sample
  // coinciding with ss rise is accounted for before deciding on frm_err.
  always_comb begin
    full_byte    = {shift[SPI_BYTE_W-2:0], sdi_q};
    next_acc     = (word_acc << SPI_BYTE_W) | WORD_W'(full_byte);
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    byte_done    = 1'b0;
    word_done    = 1'b0;
    if (sclk_rise) begin
      if (bit_cnt == 3'd7) begin
        bit_cnt_nxt = 3'd0;
        byte_done   = 1'b1;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt_nxt = '0;
          word_done    = 1'b1;
        end else begin
          byte_cnt_nxt = byte_cnt + 1'b1;
        end
      end else begin
        bit_cnt_nxt = bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      word_acc <= '0;
      byte_dat <= '0;
      byte_vld <= 1'b0;
      word_dat <= '0;
      word_vld <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      word_vld <= 1'b0;
      frm_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= RECV;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            word_acc <= '0;
          end
        end
        RECV: begin
          if (sclk_rise) begin
            shift <= full_byte;
          end
          bit_cnt  <= bit_cnt_nxt;
          byte_cnt <= byte_cnt_nxt;
          if (byte_done) begin
            byte_dat <= full_byte;
            byte_vld <= 1'b1;
            word_acc <= next_acc;
          end
          if (word_done) begin
            word_dat <= next_acc;
            word_vld <= 1'b1;
          end
          // Partial byte/word is simply dropped; the next ss fall restarts counting.
          if (ss_rise) begin
            state    <= IDLE;
            frm_err  <= (bit_cnt_nxt != 3'd0) || (byte_cnt_nxt != '0);
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_spi_sseg_rx.sv
// Self-checking bench for spi_sseg_rx: a frame-level model predicts bytes,
// words and framing errors from the bits driven onto the link.
module tb_spi_sseg_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        ss = 1'b1;
  logic        sdi = 1'b0;
  logic [7:0]  byte_dat;
  logic        byte_vld;
  logic [31:0] word_dat;
  logic        word_vld;
  logic        frm_err;
  logic        busy;

  spi_sseg_rx #(.WORD_BYTES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .sdi(sdi),
    .byte_dat(byte_dat), .byte_vld(byte_vld),
    .word_dat(word_dat), .word_vld(word_vld),
    .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  expBytes[$];
  logic [31:0] expWords[$];
  int          frameBits = 0;
  logic [31:0] frameData = '0;
  logic [31:0] lastWord = '0;
  logic [7:0]  lastByte = '0;
  int          expFrm = 0;
  int          seenFrm = 0;
  bit          idleWatch = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Every cycle: each valid pulse must match the next value the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_vld) begin
        checks++;
        if (expBytes.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_byte actual=%h expected=none", byte_dat);
        end else begin
          logic [7:0] eb;
          eb = expBytes.pop_front();
          if (byte_dat !== eb) begin
            failures++;
            $display("[TB] FAIL byte_dat actual=%h expected=%h", byte_dat, eb);
          end
        end
      end
      if (word_vld) begin
        checks++;
        if (expWords.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_word actual=%h expected=none", word_dat);
        end else begin
          logic [31:0] ew;
          ew = expWords.pop_front();
          if (word_dat !== ew) begin
            failures++;
            $display("[TB] FAIL word_dat actual=%h expected=%h", word_dat, ew);
          end
        end
      end
      if (frm_err) seenFrm++;
      if (idleWatch) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL idle_busy actual=%b expected=0", busy);
        end
      end
    end
  end

  // Drives nbits of data MSB first (sclk = clk/8) and updates the frame model.
  task automatic applyStimulus(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      #40 sclk = 1'b1;
      if (!ss) begin
        frameBits++;
        frameData = {frameData[30:0], data[i]};
        if (frameBits % 8 == 0) begin
          expBytes.push_back(frameData[7:0]);
          lastByte = frameData[7:0];
        end
        if (frameBits % 32 == 0) begin
          expWords.push_back(frameData);
          lastWord = frameData;
        end
      end
      #40 sclk = 1'b0;
    end
  endtask

  task automatic startFrame();
    @(negedge clk);
    ss = 1'b0;
    frameBits = 0;
    repeat (6) @(negedge clk);
    checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
  endtask

  task automatic endFrame(input string name);
    ss = 1'b1;
    if (frameBits % 32 != 0) expFrm++;
    frameBits = 0;
    repeat (10) @(negedge clk);
    checkOutput({name, "_bytes_left"}, expBytes.size(), 32'd0);
    checkOutput({name, "_words_left"}, expWords.size(), 32'd0);
    checkOutput({name, "_frm_err"}, seenFrm, expFrm);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_word_dat"}, word_dat, lastWord);
    checkOutput({name, "_byte_dat"}, {24'd0, byte_dat}, {24'd0, lastByte});
  endtask

  initial begin
    #1;
    checkOutput("rst_byte_dat", {24'd0, byte_dat}, 32'd0);
    checkOutput("rst_word_dat", word_dat, 32'd0);
    checkOutput("rst_flags", {28'd0, byte_vld, word_vld, frm_err, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single word");
    startFrame();
    applyStimulus(32'hDEADBEEF, 32);
    endFrame("single");
    checkOutput("lit_single_word", word_dat, 32'hDEADBEEF);
    checkOutput("lit_single_byte", {24'd0, byte_dat}, 32'h0000_00EF);
    checkOutput("lit_single_frm", seenFrm, 32'd0);

    $display("[TB] back-to-back words");
    startFrame();
    applyStimulus(32'h01234567, 32);
    applyStimulus(32'h89ABCDEF, 32);
    endFrame("b2b");
    checkOutput("lit_b2b_word", word_dat, 32'h89ABCDEF);

    $display("[TB] mid-byte abort");
    startFrame();
    applyStimulus(32'hA5A5_0000 >> 20, 12);
    endFrame("midbyte");
    checkOutput("lit_midbyte_byte", {24'd0, byte_dat}, 32'h0000_00A5);
    checkOutput("lit_midbyte_word", word_dat, 32'h89ABCDEF);
    checkOutput("lit_midbyte_frm", seenFrm, 32'd1);

    $display("[TB] mid-word abort");
    startFrame();
    applyStimulus(32'h0000_3CC3, 16);
    endFrame("midword");
    checkOutput("lit_midword_byte", {24'd0, byte_dat}, 32'h0000_00C3);
    checkOutput("lit_midword_frm", seenFrm, 32'd2);

    $display("[TB] reset mid-frame");
    startFrame();
    applyStimulus(32'h12345678 >> 12, 20);
    checkOutput("prerst_bytes_left", expBytes.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_byte_dat", {24'd0, byte_dat}, 32'd0);
    checkOutput("midrst_word_dat", word_dat, 32'd0);
    checkOutput("midrst_flags", {28'd0, byte_vld, word_vld, frm_err, busy}, 32'd0);
    ss = 1'b1;
    frameBits = 0;
    lastWord = '0;
    lastByte = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("postrst_frm_err", seenFrm, expFrm);
    startFrame();
    applyStimulus(32'h00FF00FF, 32);
    endFrame("postrst");
    checkOutput("lit_postrst_word", word_dat, 32'h00FF00FF);

    $display("[TB] idle noise");
    @(negedge clk);
    idleWatch = 1'b1;
    applyStimulus(32'h0000_F0F0, 16);
    repeat (10) @(negedge clk);
    idleWatch = 1'b0;
    checkOutput("idle_frm_err", seenFrm, expFrm);
    checkOutput("idle_word_dat", word_dat, 32'h00FF00FF);
    checkOutput("idle_bytes_left", expBytes.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
